tl_memory_access: RTL and testbench

//   MEM stage of the pipelined MIPS: data memory plus the MEM/WB pipeline latch.

---
 rtl/tl_memory_access.sv | 143 ++++++++++++++
 tb/tb_tl_memory_access.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tl_memory_access.sv
// MEM stage of the pipelined MIPS: byte-addressable data memory with sub-word
// load/store, misalignment detection and the MEM/WB pipeline latch.
module tl_memory_access #(
    parameter int len                  = 32,
    parameter int NB_CTRL_WB           = 2,
    parameter int NB_CTRL_MEM          = 5,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int NB_ADDRESS_MEM       = 7
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_valid,
    input  logic                            i_stall,
    input  logic                            i_flush,
    input  logic [len-1:0]                  i_result_alu,
    input  logic [len-1:0]                  i_write_data,
    input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
    input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
    input  logic [NB_ADDRESS_MEM-1:0]       i_debug_addr,
    output logic [len-1:0]                  o_read_data,
    output logic [len-1:0]                  o_result_alu,
    output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
    output logic                            o_valid,
    output logic                            o_misaligned,
    output logic [len-1:0]                  o_debug_data
);

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;

    logic [len-1:0] r_ram [2**NB_ADDRESS_MEM];

    logic [NB_ADDRESS_MEM-1:0] w_word_idx;
    logic [1:0]                w_offset;
    logic                      w_mem_read;
    logic                      w_mem_write;
    logic [1:0]                w_size;
    logic                      w_unsigned;
    logic                      w_misaligned;
    logic                      w_is_load;
    logic                      w_ram_we;
    logic [len-1:0]            w_word;
    logic [len-1:0]            w_shifted;
    logic [len-1:0]            w_load_data;
    logic [len-1:0]            w_store_data;
    logic [len-1:0]            w_store_mask;
    logic                      w_unused;

    // Address bits above the RAM depth are ignored, so addresses wrap.
    assign w_word_idx  = i_result_alu[NB_ADDRESS_MEM+1:2];
    assign w_offset    = i_result_alu[1:0];
    assign w_unused    = &{1'b0, i_result_alu[len-1:NB_ADDRESS_MEM+2]};

    assign w_mem_read  = i_ctrl_mem[4];
    assign w_mem_write = i_ctrl_mem[3];
    assign w_size      = i_ctrl_mem[2:1];
    assign w_unsigned  = i_ctrl_mem[0];
    assign w_is_load   = w_mem_read & ~w_mem_write;

    always_comb begin
        w_misaligned = 1'b0;
        if (i_valid && (w_mem_read || w_mem_write)) begin
            case (w_size)
                SIZE_B:  w_misaligned = 1'b0;
                SIZE_H:  w_misaligned = w_offset[0];
                default: w_misaligned = (w_offset != 2'b00);
            endcase
        end
    end

    assign w_word    = r_ram[w_word_idx];
    assign w_shifted = w_word >> {w_offset, 3'b000};

    // Lane select and extension; a word-sized load ignores the unsigned bit.
    always_comb begin
        w_load_data = '0;
        if (w_is_load && !w_misaligned) begin
            case (w_size)
                SIZE_B:  w_load_data = {{(len-8){~w_unsigned & w_shifted[7]}}, w_shifted[7:0]};
                SIZE_H:  w_load_data = {{(len-16){~w_unsigned & w_shifted[15]}}, w_shifted[15:0]};
                default: w_load_data = w_word;
            endcase
        end
    end

    always_comb begin
        w_store_data = i_write_data;
        w_store_mask = '1;
        case (w_size)
            SIZE_B: begin
                w_store_data = {(len/8){i_write_data[7:0]}};
                w_store_mask = {{(len-8){1'b0}}, 8'hFF} << {w_offset, 3'b000};
            end
            SIZE_H: begin
                w_store_data = {(len/16){i_write_data[15:0]}};
                w_store_mask = {{(len-16){1'b0}}, 16'hFFFF} << {w_offset[1], 4'b0000};
            end
            default: ;
        endcase
    end

    assign w_ram_we = i_valid & w_mem_write & ~w_misaligned & ~i_stall & ~i_flush & ~i_reset;

    // NOTE: the RAM array has no reset; clearing 128 words would prevent
    // inference of a memory and the contents are defined to survive reset.
    always_ff @(posedge i_clk) begin
        if (w_ram_we) begin
            r_ram[w_word_idx] <= (w_word & ~w_store_mask) | (w_store_data & w_store_mask);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_read_data  <= '0;
            o_result_alu <= '0;
            o_ctrl_wb    <= '0;
            o_write_reg  <= '0;
            o_valid      <= 1'b0;
            o_misaligned <= 1'b0;
        end else if (i_flush || (!i_stall && !i_valid)) begin
            o_read_data  <= '0;
            o_result_alu <= '0;
            o_ctrl_wb    <= '0;
            o_write_reg  <= '0;
            o_valid      <= 1'b0;
            o_misaligned <= 1'b0;
        end else if (!i_stall) begin
            o_read_data  <= w_load_data;
            o_result_alu <= i_result_alu;
            o_ctrl_wb    <= {i_ctrl_wb[1] & ~w_misaligned, i_ctrl_wb[0]};
            o_write_reg  <= i_write_reg;
            o_valid      <= 1'b1;
            o_misaligned <= w_misaligned;
        end
    end

    assign o_debug_data = r_ram[i_debug_addr];

endmodule

// File: tb/tb_tl_memory_access.sv
// Directed bench for tl_memory_access: sub-word loads/stores, misalignment,
// stall/flush, R-type passthrough, address wrap and asynchronous reset.
module tb_tl_memory_access;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_SW   = 5'b01110;
    localparam logic [4:0] C_SH   = 5'b01010;
    localparam logic [4:0] C_SB   = 5'b01000;
    localparam logic [4:0] C_LW   = 5'b10110;
    localparam logic [4:0] C_LH   = 5'b10010;
    localparam logic [4:0] C_LHU  = 5'b10011;
    localparam logic [4:0] C_LB   = 5'b10000;
    localparam logic [4:0] C_LBU  = 5'b10001;
    localparam logic [4:0] C_BAD  = 5'b11110;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        stall;
    logic        flush;
    logic [31:0] result_alu;
    logic [31:0] write_data;
    logic [4:0]  ctrl_mem;
    logic [1:0]  ctrl_wb;
    logic [4:0]  write_reg;
    logic [6:0]  debug_addr;
    logic [31:0] read_data_o;
    logic [31:0] result_alu_o;
    logic [1:0]  ctrl_wb_o;
    logic [4:0]  write_reg_o;
    logic        valid_o;
    logic        misaligned_o;
    logic [31:0] debug_data_o;

    int checks   = 0;
    int failures = 0;

    tl_memory_access dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_valid      (valid),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_result_alu (result_alu),
        .i_write_data (write_data),
        .i_ctrl_mem   (ctrl_mem),
        .i_ctrl_wb    (ctrl_wb),
        .i_write_reg  (write_reg),
        .i_debug_addr (debug_addr),
        .o_read_data  (read_data_o),
        .o_result_alu (result_alu_o),
        .o_ctrl_wb    (ctrl_wb_o),
        .o_write_reg  (write_reg_o),
        .o_valid      (valid_o),
        .o_misaligned (misaligned_o),
        .o_debug_data (debug_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction, clock it, and leave the bench 1 ns after the edge.
    task automatic issue(input logic [4:0] cm, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] wb, input logic [4:0] rd);
        ctrl_mem   = cm;
        result_alu = addr;
        write_data = wd;
        ctrl_wb    = wb;
        write_reg  = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string tag, input logic [6:0] word, input logic [31:0] exp);
        debug_addr = word;
        #1;
        check(tag, debug_data_o, exp);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0;
        result_alu = '0; write_data = '0; ctrl_mem = '0; ctrl_wb = '0;
        write_reg = '0; debug_addr = '0;
        #1;
        check("reset_valid", {31'd0, valid_o}, 32'd0);
        check("reset_ctrl_wb", {30'd0, ctrl_wb_o}, 32'd0);
        check("reset_read_data", read_data_o, 32'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        valid = 1'b1;

        // 1: store word then load it back on the very next edge
        issue(C_SW, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0);
        check("sw_valid", {31'd0, valid_o}, 32'd1);
        check("sw_read_data", read_data_o, 32'd0);
        issue(C_LW, 32'h10, 32'h0, 2'b11, 5'd4);
        check("lw_data", read_data_o, 32'hDEADBEEF);
        check("lw_ctrl_wb", {30'd0, ctrl_wb_o}, 32'd3);
        check("lw_write_reg", {27'd0, write_reg_o}, 32'd4);
        check("lw_misaligned", {31'd0, misaligned_o}, 32'd0);

        // 2: byte store into a cleared word, signed/unsigned byte loads
        issue(C_SW, 32'h20, 32'h0, 2'b00, 5'd0);
        issue(C_SB, 32'h21, 32'h000000A5, 2'b00, 5'd0);
        peek("sb_debug_w8", 7'd8, 32'h0000A500);
        issue(C_LB, 32'h21, 32'h0, 2'b11, 5'd5);
        check("lb_data", read_data_o, 32'hFFFFFFA5);
        issue(C_LBU, 32'h21, 32'h0, 2'b11, 5'd5);
        check("lbu_data", read_data_o, 32'h000000A5);
        issue(C_LBU, 32'h20, 32'h0, 2'b11, 5'd5);
        check("lbu_lane0", read_data_o, 32'h00000000);

        // 3: half store to upper lane, half loads, misaligned half and word
        issue(C_SW, 32'h30, 32'h0, 2'b00, 5'd0);
        issue(C_SH, 32'h32, 32'h00008001, 2'b00, 5'd0);
        peek("sh_debug_w12", 7'd12, 32'h80010000);
        issue(C_LH, 32'h32, 32'h0, 2'b11, 5'd6);
        check("lh_data", read_data_o, 32'hFFFF8001);
        issue(C_LHU, 32'h32, 32'h0, 2'b11, 5'd6);
        check("lhu_data", read_data_o, 32'h00008001);
        issue(C_LH, 32'h33, 32'h0, 2'b11, 5'd6);
        check("lh_mis_flag", {31'd0, misaligned_o}, 32'd1);
        check("lh_mis_data", read_data_o, 32'd0);
        check("lh_mis_ctrl_wb", {30'd0, ctrl_wb_o}, 32'd1);
        issue(C_SW, 32'h31, 32'hFFFFFFFF, 2'b00, 5'd0);
        check("sw_mis_flag", {31'd0, misaligned_o}, 32'd1);
        peek("sw_mis_no_write", 7'd12, 32'h80010000);
        issue(C_LW, 32'h30, 32'h0, 2'b11, 5'd6);
        check("mis_flag_clears", {31'd0, misaligned_o}, 32'd0);

        // 4: stall holds the latch and blocks the store; flush bubbles
        issue(C_SW, 32'h40, 32'h12345678, 2'b00, 5'd7);
        stall = 1'b1;
        issue(C_SW, 32'h40, 32'hCAFEF00D, 2'b11, 5'd9);
        peek("stall_no_write", 7'd16, 32'h12345678);
        check("stall_hold_alu", result_alu_o, 32'h40);
        check("stall_hold_reg", {27'd0, write_reg_o}, 32'd7);
        check("stall_hold_valid", {31'd0, valid_o}, 32'd1);
        stall = 1'b0;
        flush = 1'b1;
        issue(C_SW, 32'h40, 32'hCAFEF00D, 2'b11, 5'd9);
        peek("flush_no_write", 7'd16, 32'h12345678);
        check("flush_valid", {31'd0, valid_o}, 32'd0);
        check("flush_ctrl_wb", {30'd0, ctrl_wb_o}, 32'd0);
        check("flush_alu", result_alu_o, 32'd0);
        flush = 1'b0;

        // 5: R-type passthrough
        issue(C_NONE, 32'h00000110, 32'h0, 2'b10, 5'd9);
        check("rtype_alu", result_alu_o, 32'h110);
        check("rtype_reg", {27'd0, write_reg_o}, 32'd9);
        check("rtype_read_data", read_data_o, 32'd0);
        check("rtype_valid", {31'd0, valid_o}, 32'd1);
        check("rtype_ctrl_wb", {30'd0, ctrl_wb_o}, 32'd2);

        // i_valid=0 in the normal case latches a bubble and never stores
        valid = 1'b0;
        issue(C_SW, 32'h10, 32'h0, 2'b11, 5'd3);
        check("bubble_valid", {31'd0, valid_o}, 32'd0);
        peek("bubble_no_write", 7'd4, 32'hDEADBEEF);
        valid = 1'b1;

        // Address wrap: 0x210 maps to word 4
        issue(C_SW, 32'h00000210, 32'h0BADF00D, 2'b00, 5'd0);
        peek("wrap_debug_w4", 7'd4, 32'h0BADF00D);

        // Illegal MemRead+MemWrite behaves as a store with no load data
        issue(C_BAD, 32'h60, 32'h55AA55AA, 2'b11, 5'd2);
        check("illegal_read_data", read_data_o, 32'd0);
        peek("illegal_stored", 7'd24, 32'h55AA55AA);

        // 6: reset asserted mid-store clears outputs at once and blocks the write
        issue(C_SW, 32'h50, 32'h11111111, 2'b10, 5'd1);
        check("pre_reset_valid", {31'd0, valid_o}, 32'd1);
        ctrl_mem = C_SW; result_alu = 32'h50; write_data = 32'h22222222;
        rst = 1'b1;
        #1;
        check("async_reset_valid", {31'd0, valid_o}, 32'd0);
        check("async_reset_alu", result_alu_o, 32'd0);
        check("async_reset_reg", {27'd0, write_reg_o}, 32'd0);
        @(posedge clk); #1;
        peek("reset_no_write", 7'd20, 32'h11111111);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
